// File: rtl/pacman_mover.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pacman_mover
// Purpose  : Once-per-frame Pac-Man step engine with tile-map wall queries.
// Revision : 1.0
// ============================================================================
module pacman_mover #(
   parameter int START_X    = 108,
   parameter int START_Y    = 188,
   parameter int TUNNEL_ROW = 14
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic [31:0] control,
   output logic        query_en,
   output logic [4:0]  query_tx,
   output logic [4:0]  query_ty,
   input  logic        wall_hit,
   output logic [7:0]  pac_x,
   output logic [7:0]  pac_y,
   output logic [1:0]  dir,
   output logic        moving,
   output logic [1:0]  anim,
   output logic        overrun
);

   localparam logic [1:0] c_DIR_R      = 2'b00;
   localparam logic [1:0] c_DIR_D      = 2'b01;
   localparam logic [1:0] c_DIR_L      = 2'b10;
   localparam logic [7:0] c_START_X    = 8'(START_X);
   localparam logic [7:0] c_START_Y    = 8'(START_Y);
   localparam logic [5:0] c_TUNNEL_ROW = 6'(TUNNEL_ROW);
   localparam logic [7:0] c_X_MAX      = 8'd223;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ_Q = 3'd1,
      S_REQ_W = 3'd2,
      S_CUR_Q = 3'd3,
      S_CUR_W = 3'd4,
      S_MOVE  = 3'd5
   } state_t;

   typedef struct packed {
      logic       query;
      logic       open;
      logic [4:0] tx;
      logic [4:0] ty;
   } nbr_t;

   function automatic nbr_t f_neighbour(input logic [7:0] x, input logic [7:0] y,
                                        input logic [1:0] d);
      nbr_t       n;
      logic [5:0] tx;
      logic [5:0] ty;
      tx = {1'b0, x[7:3]};
      ty = {1'b0, y[7:3]};
      case (d)
         c_DIR_R: tx = tx + 6'd1;
         c_DIR_D: ty = ty + 6'd1;
         c_DIR_L: tx = tx - 6'd1;
         default: ty = ty - 6'd1;
      endcase
      n.tx    = tx[4:0];
      n.ty    = ty[4:0];
      n.query = (tx <= 6'd27) && (ty <= 6'd30);
      // Off-map neighbours are never queried; only the tunnel row's side exits are open.
      n.open  = !n.query && (ty == c_TUNNEL_ROW);
      return n;
   endfunction

   state_t     state_q;
   logic [7:0] x_q, y_q, x_d, y_d;
   logic [1:0] dir_q, head_q, head_d, req_dir_q, anim_q, step_q;
   logic       moving_q, overrun_q, qen_q;
   logic [4:0] qtx_q, qty_q;
   logic       req_query_q, req_adopt_q, cur_query_q, cur_open_q;

   logic       w_centred, w_ctl_valid, w_pause, w_ctl_reverse, w_ctl_turn;
   logic [1:0] w_ctl_dir;
   nbr_t       w_req_nbr, w_cur_nbr;
   logic       w_unused_ctl;

   assign w_ctl_dir     = control[1:0];
   assign w_ctl_valid   = control[2];
   assign w_pause       = control[3];
   assign w_unused_ctl  = ^control[31:4];
   assign w_centred     = (x_q[2:0] == 3'd4) && (y_q[2:0] == 3'd4);
   assign w_ctl_reverse = w_ctl_valid && (w_ctl_dir == (dir_q ^ 2'b10));
   assign w_ctl_turn    = w_ctl_valid && (w_ctl_dir != dir_q) && !w_ctl_reverse && w_centred;
   assign w_req_nbr     = f_neighbour(x_q, y_q, w_ctl_dir);
   assign w_cur_nbr     = f_neighbour(x_q, y_q, head_d);

   // Heading resolved at the end of the request wait cycle.
   always_comb begin
      head_d = dir_q;
      if (req_adopt_q || (req_query_q && !wall_hit)) begin
         head_d = req_dir_q;
      end
   end

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      case (head_q)
         c_DIR_R: x_d = (x_q == c_X_MAX) ? 8'd0 : x_q + 8'd1;
         c_DIR_D: y_d = y_q + 8'd1;
         c_DIR_L: x_d = (x_q == 8'd0) ? c_X_MAX : x_q - 8'd1;
         default: y_d = y_q - 8'd1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         x_q         <= c_START_X;
         y_q         <= c_START_Y;
         dir_q       <= c_DIR_L;
         head_q      <= c_DIR_L;
         req_dir_q   <= c_DIR_L;
         anim_q      <= 2'd0;
         step_q      <= 2'd0;
         moving_q    <= 1'b0;
         overrun_q   <= 1'b0;
         qen_q       <= 1'b0;
         qtx_q       <= 5'd0;
         qty_q       <= 5'd0;
         req_query_q <= 1'b0;
         req_adopt_q <= 1'b0;
         cur_query_q <= 1'b0;
         cur_open_q  <= 1'b0;
      end else begin
         if (frame_tick && (state_q != S_IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (frame_tick) begin
                  if (w_pause) begin
                     moving_q <= 1'b0;
                  end else begin
                     req_dir_q   <= w_ctl_dir;
                     req_adopt_q <= w_ctl_reverse || (w_ctl_turn && w_req_nbr.open);
                     req_query_q <= w_ctl_turn && w_req_nbr.query;
                     qen_q       <= w_ctl_turn && w_req_nbr.query;
                     if (w_ctl_turn && w_req_nbr.query) begin
                        qtx_q <= w_req_nbr.tx;
                        qty_q <= w_req_nbr.ty;
                     end
                     state_q <= S_REQ_Q;
                  end
               end
            end
            S_REQ_Q: begin
               qen_q   <= 1'b0;
               state_q <= S_REQ_W;
            end
            S_REQ_W: begin
               head_q      <= head_d;
               qen_q       <= w_centred && w_cur_nbr.query;
               cur_query_q <= w_centred && w_cur_nbr.query;
               cur_open_q  <= !w_centred || w_cur_nbr.open;
               if (w_centred && w_cur_nbr.query) begin
                  qtx_q <= w_cur_nbr.tx;
                  qty_q <= w_cur_nbr.ty;
               end
               state_q <= S_CUR_Q;
            end
            S_CUR_Q: begin
               qen_q   <= 1'b0;
               state_q <= S_CUR_W;
            end
            S_CUR_W: begin
               if (cur_query_q) begin
                  cur_open_q <= !wall_hit;
               end
               state_q <= S_MOVE;
            end
            S_MOVE: begin
               dir_q    <= head_q;
               moving_q <= cur_open_q;
               if (cur_open_q) begin
                  x_q    <= x_d;
                  y_q    <= y_d;
                  step_q <= step_q + 2'd1;
                  if (step_q == 2'd3) begin
                     anim_q <= anim_q + 2'd1;
                  end
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign query_en = qen_q;
   assign query_tx = qtx_q;
   assign query_ty = qty_q;
   assign pac_x    = x_q;
   assign pac_y    = y_q;
   assign dir      = dir_q;
   assign moving   = moving_q;
   assign anim     = anim_q;
   assign overrun  = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_pacman_mover.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pacman_mover
// Purpose  : Self-checking bench for pacman_mover against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_pacman_mover;

   localparam int START_X    = 108;
   localparam int START_Y    = 188;
   localparam int TUNNEL_ROW = 14;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic        frame_tick = 1'b0;
   logic [31:0] control    = '0;
   logic        wall_hit   = 1'b0;
   logic        query_en;
   logic [4:0]  query_tx, query_ty;
   logic [7:0]  pac_x, pac_y;
   logic [1:0]  dir, anim;
   logic        moving, overrun;

   always #10 clk = ~clk;

   pacman_mover #(
      .START_X    (START_X),
      .START_Y    (START_Y),
      .TUNNEL_ROW (TUNNEL_ROW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .control    (control),
      .query_en   (query_en),
      .query_tx   (query_tx),
      .query_ty   (query_ty),
      .wall_hit   (wall_hit),
      .pac_x      (pac_x),
      .pac_y      (pac_y),
      .dir        (dir),
      .moving     (moving),
      .anim       (anim),
      .overrun    (overrun)
   );

   bit maze [28][31];
   int errors = 0;
   int checks = 0;

   int m_x, m_y, m_dir, m_moving, m_steps, m_overrun;
   int phase = -1;
   int n_x, n_y, n_dir, n_moving, n_steps;
   int rq_en, rq_tx, rq_ty, cq_en, cq_tx, cq_ty;
   int qcount = 0, bad_q = 0, last_qtx = 0, last_qty = 0;
   logic pend_valid = 1'b0, pend_wall = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic look(input int x, input int y, input int d,
                       output bit q, output bit open, output int tx, output int ty);
      int dx, dy;
      dx = (d == 0) ? 1 : (d == 2) ? -1 : 0;
      dy = (d == 1) ? 1 : (d == 3) ? -1 : 0;
      tx = x / 8 + dx;
      ty = y / 8 + dy;
      q    = (tx >= 0) && (tx <= 27) && (ty >= 0) && (ty <= 30);
      open = !q && (ty == TUNNEL_ROW);
   endtask

   task automatic model_reset();
      m_x = START_X; m_y = START_Y; m_dir = 2; m_moving = 0;
      m_steps = 0; m_overrun = 0; phase = -1;
   endtask

   // Whole-frame outcome decided at the tick: turn choice, queries, step.
   task automatic plan();
      bit c, v, q, op, path;
      int d, rd, nd, tx, ty, dx, dy;
      d = m_dir; nd = d; rq_en = 0; cq_en = 0;
      c  = (m_x % 8 == 4) && (m_y % 8 == 4);
      v  = control[2];
      rd = int'(control[1:0]);
      if (v && rd == (d + 2) % 4) begin
         nd = rd;
      end else if (v && rd != d && c) begin
         look(m_x, m_y, rd, q, op, tx, ty);
         if (q) begin
            rq_en = 1; rq_tx = tx; rq_ty = ty;
            if (!maze[tx][ty]) nd = rd;
         end else if (op) begin
            nd = rd;
         end
      end
      path = 1'b1;
      if (c) begin
         look(m_x, m_y, nd, q, op, tx, ty);
         if (q) begin
            cq_en = 1; cq_tx = tx; cq_ty = ty;
            path = !maze[tx][ty];
         end else begin
            path = op;
         end
      end
      n_dir = nd; n_x = m_x; n_y = m_y; n_steps = m_steps;
      if (path) begin
         dx = (nd == 0) ? 1 : (nd == 2) ? -1 : 0;
         dy = (nd == 1) ? 1 : (nd == 3) ? -1 : 0;
         n_x = (m_x + dx + 224) % 224;
         n_y = m_y + dy;
         n_steps = m_steps + 1;
         n_moving = 1;
      end else begin
         n_moving = 0;
      end
   endtask

   // Model + per-cycle comparison.
   initial begin
      int exp_qen;
      forever begin
         @(posedge clk);
         if (reset) begin
            model_reset();
         end else if (phase < 0) begin
            if (frame_tick) begin
               if (control[3]) m_moving = 0;
               else begin
                  plan();
                  phase = 0;
               end
            end
         end else begin
            if (frame_tick) m_overrun = 1;
            phase++;
            if (phase == 5) begin
               m_x = n_x; m_y = n_y; m_dir = n_dir;
               m_moving = n_moving; m_steps = n_steps;
               phase = -1;
            end
         end
         exp_qen = (phase == 0) ? rq_en : (phase == 2) ? cq_en : 0;
         @(negedge clk);
         check("pac_x",    int'(pac_x),    m_x);
         check("pac_y",    int'(pac_y),    m_y);
         check("dir",      int'(dir),      m_dir);
         check("moving",   int'(moving),   m_moving);
         check("anim",     int'(anim),     (m_steps / 4) % 4);
         check("overrun",  int'(overrun),  m_overrun);
         check("query_en", int'(query_en), exp_qen);
         if (exp_qen != 0) begin
            check("query_tx", int'(query_tx), (phase == 0) ? rq_tx : cq_tx);
            check("query_ty", int'(query_ty), (phase == 0) ? rq_ty : cq_ty);
         end
      end
   end

   // Tile map answers one cycle after the strobe; noise otherwise.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         wall_hit   = pend_valid ? pend_wall : 1'($urandom_range(0, 1));
         pend_valid = query_en;
         pend_wall  = (query_en && query_tx <= 5'd27 && query_ty <= 5'd30) ?
                      maze[query_tx][query_ty] : 1'b0;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (query_en === 1'b1) begin
            qcount++;
            last_qtx = int'(query_tx);
            last_qty = int'(query_ty);
            if (query_tx > 5'd27 || query_ty > 5'd30) bad_q++;
         end
      end
   end

   task automatic tick(input logic [31:0] ctl);
      @(posedge clk);
      #1 frame_tick = 1'b1;
      control = ctl;
      @(posedge clk);
      #1 frame_tick = 1'b0;
      repeat (5) @(posedge clk);
      #1;
   endtask

   initial begin
      int q0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_x",   int'(pac_x), 108);
      check("rst_y",   int'(pac_y), 188);
      check("rst_dir", int'(dir), 2);
      check("rst_mov", int'(moving), 0);
      check("rst_anim", int'(anim), 0);
      check("rst_ovr", int'(overrun), 0);
      check("rst_qen", int'(query_en), 0);
      check("rst_qtx", int'(query_tx), 0);
      check("rst_qty", int'(query_ty), 0);

      q0 = qcount;
      tick(32'h0);
      check("first_x", int'(pac_x), 107);
      check("first_mov", int'(moving), 1);
      check("first_nq", qcount - q0, 1);
      check("first_qtx", last_qtx, 12);
      check("first_qty", last_qty, 23);

      q0 = qcount;
      tick(32'h4);
      check("rev_dir", int'(dir), 0);
      check("rev_x", int'(pac_x), 108);
      check("rev_nq", qcount - q0, 0);
      tick(32'h0);
      tick(32'h6);
      check("back_x", int'(pac_x), 108);

      maze[13][22] = 1'b1;
      q0 = qcount;
      tick(32'h7);
      check("wallturn_dir", int'(dir), 2);
      check("wallturn_x", int'(pac_x), 107);
      check("wallturn_nq", qcount - q0, 2);
      maze[13][22] = 1'b0;
      tick(32'h4);
      tick(32'h7);
      check("turnup_dir", int'(dir), 3);
      check("turnup_y", int'(pac_y), 187);
      tick(32'h5);
      tick(32'h6);
      tick(32'h5);
      check("perp_dir", int'(dir), 2);
      check("perp_x", int'(pac_x), 106);

      repeat (6) tick(32'h0);
      maze[11][23] = 1'b1;
      tick(32'h0);
      check("block_x", int'(pac_x), 100);
      check("block_mov", int'(moving), 0);
      check("block_anim", int'(anim), 0);
      maze[11][23] = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick(32'h0);
         if (k % 4 == 0) check("anim_adv", int'(anim), (k / 4) % 4);
      end
      check("anim_x", int'(pac_x), 84);

      check("ovr_pre", int'(overrun), 0);
      @(posedge clk);
      #1 frame_tick = 1'b1; control = 32'h0;
      @(posedge clk);
      #1 frame_tick = 1'b0;
      repeat (2) @(posedge clk);
      #1 frame_tick = 1'b1;
      @(posedge clk);
      #1 frame_tick = 1'b0;
      check("ovr_set", int'(overrun), 1);
      repeat (2) @(posedge clk);
      #1;
      check("ovr_x", int'(pac_x), 83);

      q0 = qcount;
      tick(32'h8);
      check("pause_mov", int'(moving), 0);
      check("pause_nq", qcount - q0, 0);

      @(posedge clk);
      #1 frame_tick = 1'b1; control = 32'h0;
      @(posedge clk);
      #1 frame_tick = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("midrst_x", int'(pac_x), 108);
      check("midrst_ovr", int'(overrun), 0);
      check("midrst_qen", int'(query_en), 0);
      repeat (8) @(posedge clk);
      #1;
      check("midrst_hold", int'(pac_x), 108);

      tick(32'h7);
      for (int k = 0; k < 71; k++) tick(32'h0);
      check("tun_y", int'(pac_y), 116);
      tick(32'h6);
      for (int k = 0; k < 107; k++) tick(32'h0);
      check("tun_x0", int'(pac_x), 0);
      tick(32'h0);
      check("tun_wrapL", int'(pac_x), 223);
      repeat (3) tick(32'h0);
      tick(32'h4);
      repeat (3) tick(32'h0);
      check("tun_wrapR", int'(pac_x), 0);
      check("tun_qrange", bad_q, 0);

      for (int tx = 0; tx < 28; tx++) begin
         for (int ty = 0; ty < 31; ty++) begin
            if (tx == 0 || tx == 27 || ty == 0 || ty == 30)
               maze[tx][ty] = (ty != TUNNEL_ROW);
            else
               maze[tx][ty] = ($urandom_range(0, 3) == 0);
         end
      end
      maze[13][23] = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int k = 0; k < 600; k++) begin
         int gap;
         gap = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 9);
         control = $urandom;
         if ($urandom_range(0, 7) != 0) control[3] = 1'b0;
         if ($urandom_range(0, 3) != 0) control[2] = 1'b1;
         frame_tick = 1'b1;
         @(posedge clk);
         #1 frame_tick = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
      repeat (10) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
